// File: rtl/atomrvcore_lsu_if.sv
// Request, DCCM and writeback signals of the load/store unit.
// master: the LSU itself; slave: the execute/DCCM/writeback side.
interface atomrvcore_lsu_if #(
    parameter int unsigned DATAWIDTH        = 32,
    parameter int unsigned REG_ADRESS_WIDTH = 5
);
    logic                        req_valid_i;
    logic                        req_ready_o;
    logic                        req_store_i;
    logic [2:0]                  req_funct3_i;
    logic [DATAWIDTH-1:0]        req_addr_i;
    logic [DATAWIDTH-1:0]        req_wdata_i;
    logic [REG_ADRESS_WIDTH-1:0] req_rd_i;
    logic [DATAWIDTH-1:0]        dccm_addr_o;
    logic                        dccm_dr_en_o;
    logic [DATAWIDTH-1:0]        dccm_dt_i;
    logic                        dccm_dwr_en_o;
    logic [DATAWIDTH-1:0]        dccm_dt_o;
    logic                        wb_valid_o;
    logic                        wb_ready_i;
    logic                        wb_rwr_en_o;
    logic [REG_ADRESS_WIDTH-1:0] wb_rd_o;
    logic [DATAWIDTH-1:0]        wb_data_o;
    logic                        wb_err_o;

    modport master (
        input  req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  dccm_dt_i, wb_ready_i,
        output req_ready_o, dccm_addr_o, dccm_dr_en_o, dccm_dwr_en_o, dccm_dt_o,
        output wb_valid_o, wb_rwr_en_o, wb_rd_o, wb_data_o, wb_err_o
    );

    modport slave (
        output req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output dccm_dt_i, wb_ready_i,
        input  req_ready_o, dccm_addr_o, dccm_dr_en_o, dccm_dwr_en_o, dccm_dt_o,
        input  wb_valid_o, wb_rwr_en_o, wb_rd_o, wb_data_o, wb_err_o
    );
endinterface

// File: rtl/atomrvcore_lsu.sv
// Load/store unit between execute and the word-wide DCCM.
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
module atomrvcore_lsu #(
    parameter int unsigned DATAWIDTH        = 32,
    parameter int unsigned REG_ADRESS_WIDTH = 5
) (
    input logic              clk_i,
    input logic              rst_ni,
    atomrvcore_lsu_if.master bus
);
    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp, StErrResp} state_e;

    state_e                      state_q;
    logic [1:0]                  lane_q;
    logic [2:0]                  funct3_q;
    logic [REG_ADRESS_WIDTH-1:0] rd_q;
    logic [15:0]                 wdata_q;

    logic                        req_ready_q;
    logic [DATAWIDTH-1:0]        dccm_addr_q;
    logic                        dr_en_q;
    logic                        dwr_en_q;
    logic [DATAWIDTH-1:0]        dt_o_q;
    logic                        wb_valid_q;
    logic                        wb_rwr_en_q;
    logic [REG_ADRESS_WIDTH-1:0] wb_rd_q;
    logic [DATAWIDTH-1:0]        wb_data_q;
    logic                        wb_err_q;

    logic                        req_legal;
    logic                        req_misaligned;
    logic [7:0]                  ld_byte;
    logic [15:0]                 ld_half;
    logic [DATAWIDTH-1:0]        ld_val;
    logic [DATAWIDTH-1:0]        merged;

    // Decode legality and alignment of the presented request.
    always_comb begin
        req_legal = 1'b0;
        case (bus.req_funct3_i)
            F3B, F3H, F3W: req_legal = 1'b1;
            F3BU, F3HU:    req_legal = !bus.req_store_i;
            default:       req_legal = 1'b0;
        endcase
        req_misaligned = 1'b0;
        if (bus.req_funct3_i[1:0] == 2'b01) begin
            req_misaligned = bus.req_addr_i[0];
        end else if (bus.req_funct3_i[1:0] == 2'b10) begin
            req_misaligned = |bus.req_addr_i[1:0];
        end
    end

    // Lane extraction for loads and byte-lane merge for sub-word stores.
    always_comb begin
        ld_byte = bus.dccm_dt_i[{lane_q, 3'b000} +: 8];
        ld_half = bus.dccm_dt_i[{lane_q[1], 4'b0000} +: 16];
        case (funct3_q)
            F3B:     ld_val = {{(DATAWIDTH-8){ld_byte[7]}}, ld_byte};
            F3H:     ld_val = {{(DATAWIDTH-16){ld_half[15]}}, ld_half};
            F3BU:    ld_val = {{(DATAWIDTH-8){1'b0}}, ld_byte};
            F3HU:    ld_val = {{(DATAWIDTH-16){1'b0}}, ld_half};
            default: ld_val = bus.dccm_dt_i;
        endcase
        merged = bus.dccm_dt_i;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Operation FSM; every output is registered on the transition into its state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            lane_q      <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            dccm_addr_q <= '0;
            dr_en_q     <= 1'b0;
            dwr_en_q    <= 1'b0;
            dt_o_q      <= '0;
            wb_valid_q  <= 1'b0;
            wb_rwr_en_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid_i) begin
                        lane_q      <= bus.req_addr_i[1:0];
                        funct3_q    <= bus.req_funct3_i;
                        rd_q        <= bus.req_rd_i;
                        wdata_q     <= bus.req_wdata_i[15:0];
                        req_ready_q <= 1'b0;
                        if (!req_legal || req_misaligned) begin
                            state_q    <= StErrResp;
                            wb_valid_q <= 1'b1;
                            wb_err_q   <= 1'b1;
                            wb_rd_q    <= bus.req_rd_i;
                        end else begin
                            dccm_addr_q <= {bus.req_addr_i[DATAWIDTH-1:2], 2'b00};
                            if (!bus.req_store_i) begin
                                state_q <= StLoad;
                                dr_en_q <= 1'b1;
                            end else if (bus.req_funct3_i == F3W) begin
                                state_q  <= StWrite;
                                dwr_en_q <= 1'b1;
                                dt_o_q   <= bus.req_wdata_i;
                            end else begin
                                state_q <= StRmwRd;
                                dr_en_q <= 1'b1;
                            end
                        end
                    end
                end
                StLoad: begin
                    state_q     <= StResp;
                    dr_en_q     <= 1'b0;
                    wb_valid_q  <= 1'b1;
                    wb_data_q   <= ld_val;
                    wb_rwr_en_q <= (rd_q != '0);
                    wb_rd_q     <= rd_q;
                end
                StRmwRd: begin
                    state_q  <= StWrite;
                    dr_en_q  <= 1'b0;
                    dwr_en_q <= 1'b1;
                    dt_o_q   <= merged;
                end
                StWrite: begin
                    state_q    <= StResp;
                    dwr_en_q   <= 1'b0;
                    dt_o_q     <= '0;
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= rd_q;
                end
                StResp, StErrResp: begin
                    if (bus.wb_ready_i) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        dccm_addr_q <= '0;
                        wb_valid_q  <= 1'b0;
                        wb_rwr_en_q <= 1'b0;
                        wb_rd_q     <= '0;
                        wb_data_q   <= '0;
                        wb_err_q    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready_o   = req_ready_q;
    assign bus.dccm_addr_o   = dccm_addr_q;
    assign bus.dccm_dr_en_o  = dr_en_q;
    // Gated by reset so a write pending when reset is sampled never lands.
    assign bus.dccm_dwr_en_o = dwr_en_q & rst_ni;
    assign bus.dccm_dt_o     = dt_o_q;
    assign bus.wb_valid_o    = wb_valid_q;
    assign bus.wb_rwr_en_o   = wb_rwr_en_q;
    assign bus.wb_rd_o       = wb_rd_q;
    assign bus.wb_data_o     = wb_data_q;
    assign bus.wb_err_o      = wb_err_q;
endmodule

// File: tb/tb_atomrvcore_lsu.sv
// Self-checking bench for atomrvcore_lsu: behavioural model plus directed literals.
module tb_atomrvcore_lsu;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atomrvcore_lsu_if #(.DATAWIDTH(DW), .REG_ADRESS_WIDTH(RW)) bus();

    atomrvcore_lsu #(.DATAWIDTH(DW), .REG_ADRESS_WIDTH(RW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Environment DCCM (driven by DUT) and the model's view of memory.
    logic [31:0] mem       [64];
    logic [31:0] model_mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    assign bus.dccm_dt_i = mem[bus.dccm_addr_o[7:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (bus.dccm_dwr_en_o) mem[bus.dccm_addr_o[7:2]] <= bus.dccm_dt_o;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Model of the operation in flight: cycle index since accept and expectations.
    logic        m_busy = 1'b0;
    int          m_k, m_lat, m_wcyc;
    logic        m_nread, m_err, m_rwr;
    logic [31:0] m_data, m_word;
    logic [4:0]  m_rd;
    logic [5:0]  m_widx;

    task automatic model_accept(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [4:0] rd);
        int size, off;
        logic legal;
        logic [31:0] mask, w, raw;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        off   = int'(addr[1:0]);
        m_err = !legal || (off % size != 0);
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        w     = model_mem[addr[7:2]];
        m_widx = addr[7:2];
        m_rd = rd; m_k = 1; m_busy = 1'b1;
        m_data = '0; m_rwr = 1'b0; m_nread = 1'b0; m_wcyc = 0; m_word = '0;
        if (m_err) begin
            m_lat = 1;
        end else if (!st) begin
            raw = (w >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
            m_data = raw; m_rwr = (rd != 5'd0); m_lat = 2; m_nread = 1'b1;
        end else begin
            m_word = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            if (size == 4) begin
                m_lat = 2; m_wcyc = 1;
            end else begin
                m_lat = 3; m_nread = 1'b1; m_wcyc = 2;
            end
        end
    endtask

    // Compare process: check outputs mid-cycle, then advance the model to the next edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("dr_dwr_exclusive", 32'(bus.dccm_dr_en_o & bus.dccm_dwr_en_o), 32'd0);
            if (!m_busy) begin
                chk("idle_req_ready", 32'(bus.req_ready_o), 32'd1);
                chk("idle_wb_valid", 32'(bus.wb_valid_o), 32'd0);
                chk("idle_dr_en", 32'(bus.dccm_dr_en_o), 32'd0);
                chk("idle_dwr_en", 32'(bus.dccm_dwr_en_o), 32'd0);
                chk("idle_dccm_addr", bus.dccm_addr_o, 32'd0);
                chk("idle_dccm_dt_o", bus.dccm_dt_o, 32'd0);
                chk("idle_wb_err", 32'(bus.wb_err_o), 32'd0);
                chk("idle_wb_rwr", 32'(bus.wb_rwr_en_o), 32'd0);
                chk("idle_wb_data", bus.wb_data_o, 32'd0);
                chk("idle_wb_rd", 32'(bus.wb_rd_o), 32'd0);
            end else begin
                chk("busy_req_ready", 32'(bus.req_ready_o), 32'd0);
                chk("dr_en", 32'(bus.dccm_dr_en_o), 32'(m_nread && m_k == 1));
                chk("dwr_en", 32'(bus.dccm_dwr_en_o), 32'(m_wcyc != 0 && m_k == m_wcyc));
                if ((m_nread && m_k == 1) || (m_wcyc != 0 && m_k == m_wcyc))
                    chk("dccm_addr", bus.dccm_addr_o, {24'h0, m_widx, 2'b00});
                if (m_wcyc != 0 && m_k == m_wcyc) chk("dccm_dt_o", bus.dccm_dt_o, m_word);
                chk("wb_valid", 32'(bus.wb_valid_o), 32'(m_k >= m_lat));
                if (m_k >= m_lat) begin
                    chk("wb_err", 32'(bus.wb_err_o), 32'(m_err));
                    chk("wb_data", bus.wb_data_o, m_data);
                    chk("wb_rwr_en", 32'(bus.wb_rwr_en_o), 32'(m_rwr));
                    chk("wb_rd", 32'(bus.wb_rd_o), 32'(m_rd));
                end
            end
            if (!rst_n) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (bus.req_valid_i)
                    model_accept(bus.req_store_i, bus.req_funct3_i, bus.req_addr_i,
                                 bus.req_wdata_i, bus.req_rd_i);
            end else begin
                if (m_wcyc != 0 && m_k == m_wcyc) model_mem[m_widx] = m_word;
                if (m_k >= m_lat && bus.wb_ready_i) m_busy = 1'b0;
                else if (m_k < m_lat) m_k++;
            end
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        model_mem[idx] = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One operation; called 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input int hold,
                          input logic junk, output logic [31:0] got_data,
                          output logic got_err, output logic got_rwr);
        int n;
        bus.req_valid_i = 1'b1; bus.req_store_i = st; bus.req_funct3_i = f3;
        bus.req_addr_i = addr; bus.req_wdata_i = wd; bus.req_rd_i = rd;
        bus.wb_ready_i = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid_i = junk;
        if (junk) begin
            bus.req_store_i = 1'($urandom); bus.req_funct3_i = 3'($urandom);
            bus.req_addr_i = {24'h0, 8'($urandom)}; bus.req_wdata_i = $urandom;
            bus.req_rd_i = 5'($urandom);
        end
        n = 0;
        while (!bus.wb_valid_o && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wb_valid_wait", 32'(bus.wb_valid_o), 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.wb_ready_i = 1'b1;
        got_data = bus.wb_data_o; got_err = bus.wb_err_o; got_rwr = bus.wb_rwr_en_o;
        @(posedge clk); #1;
        bus.wb_ready_i = 1'b0; bus.req_valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e, r, st;
        logic [2:0]  f3;
        logic [31:0] a;
        bus.req_valid_i = 1'b0; bus.req_store_i = 1'b0; bus.req_funct3_i = '0;
        bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_rd_i = '0; bus.wb_ready_i = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Loads from 0x40.
        preload(6'd16, 32'h8899AABB);
        run_op(1'b0, 3'b000, 32'h41, 32'h0, 5'd5, 0, 1'b0, d, e, r);
        chk("t1_lb_data", d, 32'hFFFFFFAA);
        chk("t1_lb_rwr", 32'(r), 32'd1);
        run_op(1'b0, 3'b100, 32'h43, 32'h0, 5'd6, 0, 1'b0, d, e, r);
        chk("t1_lbu_data", d, 32'h00000088);
        run_op(1'b0, 3'b001, 32'h42, 32'h0, 5'd7, 0, 1'b0, d, e, r);
        chk("t2_lh_data", d, 32'hFFFF8899);
        run_op(1'b0, 3'b101, 32'h40, 32'h0, 5'd8, 0, 1'b0, d, e, r);
        chk("t2_lhu_data", d, 32'h0000AABB);
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 5'd9, 0, 1'b0, d, e, r);
        chk("t2_lw_data", d, 32'h8899AABB);

        // Sub-word stores into 0x80.
        preload(6'd32, 32'h11223344);
        run_op(1'b1, 3'b000, 32'h81, 32'hDEADBEEF, 5'd0, 0, 1'b0, d, e, r);
        chk("t3_sb_mem", mem[32], 32'h1122EF44);
        chk("t3_sb_rwr", 32'(r), 32'd0);
        preload(6'd32, 32'h11223344);
        run_op(1'b1, 3'b001, 32'h82, 32'h0000CAFE, 5'd0, 1, 1'b0, d, e, r);
        chk("t3_sh_mem", mem[32], 32'hCAFE3344);

        // Errors.
        run_op(1'b0, 3'b010, 32'h42, 32'h0, 5'd3, 0, 1'b0, d, e, r);
        chk("t4_lw_mis_err", 32'(e), 32'd1);
        chk("t4_lw_mis_rwr", 32'(r), 32'd0);
        run_op(1'b1, 3'b001, 32'h83, 32'h1234, 5'd3, 0, 1'b0, d, e, r);
        chk("t4_sh_mis_err", 32'(e), 32'd1);
        run_op(1'b0, 3'b011, 32'h40, 32'h0, 5'd3, 0, 1'b0, d, e, r);
        chk("t4_f3_011_err", 32'(e), 32'd1);
        chk("t4_f3_011_data", d, 32'd0);

        // Backpressure with a competing request held valid.
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 5'd12, 5, 1'b1, d, e, r);
        chk("t5_lw_hold_data", d, 32'h8899AABB);

        // Reset during the read phase of an SB.
        preload(6'd32, 32'h11223344);
        bus.req_valid_i = 1'b1; bus.req_store_i = 1'b1; bus.req_funct3_i = 3'b000;
        bus.req_addr_i = 32'h81; bus.req_wdata_i = 32'hDEADBEEF; bus.req_rd_i = 5'd0;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_mem_kept", mem[32], 32'h11223344);
        chk("t6_req_ready", 32'(bus.req_ready_o), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom);
            f3 = 3'($urandom);
            a  = {24'h0, 8'($urandom)};
            if ($urandom_range(0, 2) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            run_op(st, f3, a, $urandom, 5'($urandom), int'($urandom_range(0, 2)),
                   1'($urandom), d, e, r);
        end

        for (int i = 0; i < 64; i++) chk("mem_final", mem[i], model_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
